// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - N-channel LED pattern sequencer (rotate/bounce/blink), optional ack via LED_SEQ_ACK_EN
module led_pattern_seq #(
    parameter int NUM_LEDS = 3,
    parameter int CLK_HZ   = 24_000_000,
    parameter int STEP_HZ  = 1
) (
    input  logic                CLK_IN,
    input  logic                RST_N,
    input  logic                CMD_VALID,
    input  logic [7:0]          CMD_DATA,
    output logic [NUM_LEDS-1:0] LED,
    output logic                STEP_PULSE,
    output logic [1:0]          MODE,
    output logic                ACK_VALID,
    output logic [7:0]          ACK_DATA,
    input  logic                ACK_READY
);

    localparam int BASE = CLK_HZ / STEP_HZ;
    localparam int CW   = (BASE > 1) ? $clog2(BASE) : 1;

    localparam logic [7:0] CMD_ROTATE = 8'h72;
    localparam logic [7:0] CMD_BOUNCE = 8'h62;
    localparam logic [7:0] CMD_BLINK  = 8'h6B;
    localparam logic [7:0] CMD_PAUSE  = 8'h70;
    localparam logic [7:0] CMD_FASTER = 8'h2B;
    localparam logic [7:0] CMD_SLOWER = 8'h2D;

    typedef enum logic [1:0] {
        M_ROTATE = 2'b00,
        M_BOUNCE = 2'b01,
        M_BLINK  = 2'b10
    } mode_t;

    mode_t               mode_q;
    logic [NUM_LEDS-1:0] led_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       last_cnt;
    logic [1:0]          speed_q;
    logic                paused_q;
    logic                dir_up_q;
    logic                pulse_q;
    logic                tick;
    logic                cmd_known;

    // Terminal count shrinks by a power of two per speed level
    always_comb begin
        last_cnt  = CW'((BASE >> speed_q) - 1);
        tick      = !paused_q && (cnt_q == last_cnt);
        cmd_known = (CMD_DATA == CMD_ROTATE) || (CMD_DATA == CMD_BOUNCE) ||
                    (CMD_DATA == CMD_BLINK)  || (CMD_DATA == CMD_PAUSE)  ||
                    (CMD_DATA == CMD_FASTER) || (CMD_DATA == CMD_SLOWER);
    end

    // Prescaler, command decode and pattern stepping; a command in a tick cycle swallows the step
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            mode_q   <= M_ROTATE;
            led_q    <= NUM_LEDS'(1);
            cnt_q    <= '0;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            dir_up_q <= 1'b1;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (!paused_q)
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (CMD_VALID) begin
                case (CMD_DATA)
                    CMD_ROTATE, CMD_BOUNCE, CMD_BLINK: begin
                        cnt_q    <= '0;
                        dir_up_q <= 1'b1;
                        if (CMD_DATA == CMD_BLINK) begin
                            mode_q <= M_BLINK;
                            led_q  <= '0;
                        end else begin
                            mode_q <= (CMD_DATA == CMD_ROTATE) ? M_ROTATE : M_BOUNCE;
                            led_q  <= NUM_LEDS'(1);
                        end
                    end
                    CMD_PAUSE: paused_q <= !paused_q;
                    CMD_FASTER: begin
                        cnt_q <= '0;
                        if (speed_q != 2'd3)
                            speed_q <= speed_q + 2'd1;
                    end
                    CMD_SLOWER: begin
                        cnt_q <= '0;
                        if (speed_q != 2'd0)
                            speed_q <= speed_q - 2'd1;
                    end
                    default: ;
                endcase
            end else if (tick) begin
                pulse_q <= 1'b1;
                case (mode_q)
                    M_BLINK: led_q <= (led_q == '0) ? '1 : '0;
                    M_BOUNCE: begin
                        if (NUM_LEDS == 1) begin
                            led_q <= led_q;
                        end else if (dir_up_q && led_q[NUM_LEDS-1]) begin
                            dir_up_q <= 1'b0;
                            led_q    <= led_q >> 1;
                        end else if (!dir_up_q && led_q[0]) begin
                            dir_up_q <= 1'b1;
                            led_q    <= led_q << 1;
                        end else begin
                            led_q <= dir_up_q ? (led_q << 1) : (led_q >> 1);
                        end
                    end
                    default: led_q <= (led_q << 1) | (led_q >> (NUM_LEDS - 1));
                endcase
            end
        end
    end

    assign LED        = led_q;
    assign STEP_PULSE = pulse_q;
    assign MODE       = mode_q;

`ifdef LED_SEQ_ACK_EN
    logic       ack_valid_q;
    logic [7:0] ack_data_q;

    // Single-entry ack holding register; commands arriving while it is full lose their ack
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= 8'h00;
        end else if (ack_valid_q && ACK_READY) begin
            ack_valid_q <= 1'b0;
        end else if (CMD_VALID && !ack_valid_q) begin
            ack_valid_q <= 1'b1;
            ack_data_q  <= cmd_known ? CMD_DATA : 8'h3F;
        end
    end

    assign ACK_VALID = ack_valid_q;
    assign ACK_DATA  = ack_data_q;
`else
    logic unused_ack;
    assign unused_ack = ACK_READY ^ cmd_known;
    assign ACK_VALID  = 1'b0;
    assign ACK_DATA   = 8'h00;
`endif

endmodule
